// File: rtl/meminst_loader.sv
// meminst_loader: boot/reload controller for the instruction memory bank.
// Takes a counted stream of instruction words after a start pulse and writes
// them to consecutive addresses from 0. It then holds the CPU for a two-cycle
// flush and finally passes the CPU program counter through as the read address.
//
// Handshake: a word transfers at a rising edge where dado_valid && dado_ready.
// dado_ready depends only on the state (high throughout LOAD) and never on
// dado_valid. The source may change dado_in freely while dado_valid is low.
// Words offered outside LOAD are not consumed.
module meminst_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock_auto,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_palavras,
  input  logic [DATA_W-1:0] dado_in,
  input  logic              dado_valid,
  output logic              dado_ready,
  input  logic [31:0]       pc,
  output logic              OpMemIns,
  output logic [DATA_W-1:0] instrucao,
  output logic [31:0]       endLeitura,
  output logic [31:0]       endereco,
  output logic              cpu_hold,
  output logic              done,
  output logic              erro,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Largest word count that fits the memory: exactly 2**ADDR_W.
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   count_lat;   // word count latched on an accepted start
  logic [ADDR_W:0]   addr_cnt;    // next write address; also the words taken so far
  logic [ADDR_W:0]   addr_inc;
  logic              flush_cnt;   // 0 in flush cycle 1, 1 in flush cycle 2

  logic              start_take;  // start seen in a state that listens to it
  logic              count_big;
  logic              count_zero;
  logic              xfer;
  logic              last_xfer;

  // Decode the start request, the handshake and the end of the stream.
  always_comb begin
    start_take = start && ((state == ST_IDLE) || (state == ST_RUN));
    count_big  = num_palavras > MAX_COUNT;
    count_zero = num_palavras == '0;
    xfer       = (state == ST_LOAD) && dado_valid;
    addr_inc   = addr_cnt + ONE_COUNT;
    last_xfer  = xfer && (addr_inc == count_lat);
  end

  // Next-state logic; IDLE and RUN share the same start rules.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (start_take) begin
          if (count_big) begin
            state_nx = ST_IDLE;
          end else if (count_zero) begin
            state_nx = ST_FLUSH;
          end else begin
            state_nx = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (last_xfer) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt) begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs derived purely from the state (and pc while running).
  always_comb begin
    dado_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    endereco   = 32'd0;
    state_dbg  = state;
    case (state)
      ST_LOAD: dado_ready = 1'b1;
      ST_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        endereco = pc;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clock_auto) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Flush interval counter; it restarts whenever the FSM is outside FLUSH.
  always_ff @(posedge clock_auto) begin
    if (!reset_n) begin
      flush_cnt <= 1'b0;
    end else begin
      flush_cnt <= (state == ST_FLUSH) && !flush_cnt;
    end
  end

  // Sticky error flag and the latched count on start requests.
  always_ff @(posedge clock_auto) begin
    if (!reset_n) begin
      erro      <= 1'b0;
      count_lat <= '0;
    end else if (start_take) begin
      if (count_big) begin
        erro <= 1'b1;
      end else begin
        erro      <= 1'b0;
        count_lat <= num_palavras;
      end
    end
  end

  // Address counter: cleared on an accepted start, stepped on each transfer.
  always_ff @(posedge clock_auto) begin
    if (!reset_n) begin
      addr_cnt <= '0;
    end else if (start_take && !count_big) begin
      addr_cnt <= '0;
    end else if (xfer) begin
      addr_cnt <= addr_inc;
    end
  end

  // Memory write port: registered one cycle behind the handshake. Data and
  // address hold between writes; the enable is a single-cycle strobe.
  always_ff @(posedge clock_auto) begin
    if (!reset_n) begin
      OpMemIns   <= 1'b0;
      instrucao  <= '0;
      endLeitura <= 32'd0;
    end else begin
      OpMemIns <= 1'b0;
      if (xfer) begin
        OpMemIns   <= 1'b1;
        instrucao  <= dado_in;
        endLeitura <= {{(32-ADDR_W){1'b0}}, addr_cnt[ADDR_W-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_meminst_loader.sv
// Directed bench for meminst_loader: a behavioural instruction memory records
// every write strobe, and each step checks outputs against hand-worked values.
module tb_meminst_loader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  // Clock and reset block.
  logic              clock_auto = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W:0]   num_palavras;
  logic [DATA_W-1:0] dado_in;
  logic              dado_valid;
  logic              dado_ready;
  logic [31:0]       pc;
  logic              OpMemIns;
  logic [DATA_W-1:0] instrucao;
  logic [31:0]       endLeitura;
  logic [31:0]       endereco;
  logic              cpu_hold;
  logic              done;
  logic              erro;
  logic [1:0]        state_dbg;

  always #5 clock_auto = ~clock_auto;

  meminst_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock_auto   (clock_auto),
    .reset_n      (reset_n),
    .start        (start),
    .num_palavras (num_palavras),
    .dado_in      (dado_in),
    .dado_valid   (dado_valid),
    .dado_ready   (dado_ready),
    .pc           (pc),
    .OpMemIns     (OpMemIns),
    .instrucao    (instrucao),
    .endLeitura   (endLeitura),
    .endereco     (endereco),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .erro         (erro),
    .state_dbg    (state_dbg)
  );

  // Scoreboard: expected writes as {address, data}, observed writes likewise.
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] w [0:2];

  // Instruction memory model: write on the strobe at the rising edge.
  always @(posedge clock_auto) begin
    if (OpMemIns) begin
      got_q.push_back({endLeitura, instrucao});
      mem[endLeitura[7:0]] <= instrucao;
    end
  end

  task automatic tick();
    @(posedge clock_auto);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_entry"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    w[0] = 32'h2008_0005;
    w[1] = 32'h2009_0007;
    w[2] = 32'h0109_5020;
    reset_n = 1'b0; start = 1'b0; num_palavras = '0;
    dado_in = '0; dado_valid = 1'b0; pc = 32'd0;

    // Reset state.
    tick(); tick();
    chk("rst_opmem", OpMemIns, 0);
    chk("rst_instr", instrucao, 0);
    chk("rst_endl", endLeitura, 0);
    chk("rst_ready", dado_ready, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_erro", erro, 0);
    chk("rst_ender", endereco, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_state", state_dbg, 0);

    // Three words back-to-back.
    start = 1'b1; num_palavras = 15'd3;
    tick();
    start = 1'b0; num_palavras = '0;
    chk("t1_state_load", state_dbg, 1);
    chk("t1_ready", dado_ready, 1);
    chk("t1_hold", cpu_hold, 1);
    chk("t1_opmem_pre", OpMemIns, 0);
    for (int i = 0; i < 3; i++) begin
      dado_valid = 1'b1; dado_in = w[i];
      expect_write(32'(i), w[i]);
      tick();
      chk("t1_opmem", OpMemIns, 1);
      chk("t1_endl", endLeitura, 64'(i));
      chk("t1_instr", instrucao, w[i]);
    end
    chk("t1_state_flush", state_dbg, 2);
    chk("t1_ready_flush", dado_ready, 0);
    chk("t1_hold_flush", cpu_hold, 1);
    dado_valid = 1'b0; dado_in = '0;
    tick();
    chk("t1_flush2_opmem", OpMemIns, 0);
    chk("t1_flush2_state", state_dbg, 2);
    chk("t1_flush2_done", done, 0);
    tick();
    chk("t1_run_state", state_dbg, 3);
    chk("t1_run_done", done, 1);
    chk("t1_run_hold", cpu_hold, 0);
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i);
      #1;
      chk("t1_ender", endereco, 64'(i));
      chk("t1_readback", mem[endereco[7:0]], w[i]);
    end
    check_writes("t1");

    // Words offered in RUN are ignored.
    dado_valid = 1'b1; dado_in = 32'hBAD0_BAD0;
    tick(); tick();
    chk("run_ignore_opmem", OpMemIns, 0);
    check_writes("run_ignore");
    dado_valid = 1'b0;

    // Same load with dado_valid on every other cycle, restarted from RUN.
    start = 1'b1; num_palavras = 15'd3;
    tick();
    start = 1'b0;
    chk("t2_state_load", state_dbg, 1);
    chk("t2_done_drop", done, 0);
    for (int i = 0; i < 6; i++) begin
      dado_valid = (i % 2 == 0);
      dado_in = (i % 2 == 0) ? w[i/2] : 32'hDEAD_BEEF;
      if (i % 2 == 0) expect_write(32'(i/2), w[i/2]);
      tick();
      chk("t2_opmem", OpMemIns, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_endl", endLeitura, 64'(i/2));
      chk("t2_instr", instrucao, w[i/2]);
    end
    dado_valid = 1'b0;
    chk("t2_state_flush2", state_dbg, 2);
    tick();
    chk("t2_run_done", done, 1);
    check_writes("t2");

    // Oversized count is rejected; a following count of 1 clears erro.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    start = 1'b1; num_palavras = 15'd16385; dado_valid = 1'b1; dado_in = 32'h1111_1111;
    tick();
    start = 1'b0;
    chk("t3_erro_set", erro, 1);
    chk("t3_state_idle", state_dbg, 0);
    chk("t3_ready", dado_ready, 0);
    chk("t3_opmem", OpMemIns, 0);
    tick();
    chk("t3_opmem2", OpMemIns, 0);
    chk("t3_erro_sticky", erro, 1);
    check_writes("t3_nowrite");
    start = 1'b1; num_palavras = 15'd1; dado_in = 32'hCAFE_F00D;
    tick();
    start = 1'b0;
    chk("t3_erro_clear", erro, 0);
    chk("t3_state_load", state_dbg, 1);
    expect_write(32'd0, 32'hCAFE_F00D);
    tick();
    chk("t3_opmem_one", OpMemIns, 1);
    chk("t3_endl_one", endLeitura, 0);
    chk("t3_state_flush", state_dbg, 2);
    dado_valid = 1'b0;
    tick(); tick();
    chk("t3_done", done, 1);
    check_writes("t3");

    // Oversized count from RUN drops to IDLE with erro.
    start = 1'b1; num_palavras = 15'd32767;
    tick();
    start = 1'b0;
    chk("t3r_state", state_dbg, 0);
    chk("t3r_erro", erro, 1);
    chk("t3r_done", done, 0);
    chk("t3r_hold", cpu_hold, 1);

    // Count of exactly 2**ADDR_W is accepted and does not finish early.
    start = 1'b1; num_palavras = 15'd16384;
    tick();
    start = 1'b0;
    chk("tmax_state", state_dbg, 1);
    chk("tmax_erro", erro, 0);
    chk("tmax_ready", dado_ready, 1);
    dado_valid = 1'b1; dado_in = 32'h1234_5678;
    expect_write(32'd0, 32'h1234_5678);
    tick();
    dado_valid = 1'b0;
    chk("tmax_opmem", OpMemIns, 1);
    chk("tmax_still_load", state_dbg, 1);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("tmax_reset_state", state_dbg, 0);
    check_writes("tmax");

    // Zero count: done exactly three cycles after start.
    start = 1'b1; num_palavras = 15'd0;
    tick();
    start = 1'b0;
    chk("t4_c1_state", state_dbg, 2);
    chk("t4_c1_done", done, 0);
    tick();
    chk("t4_c2_done", done, 0);
    tick();
    chk("t4_c3_done", done, 1);
    check_writes("t4_zero");

    // A start pulse inside LOAD does not change the count.
    start = 1'b1; num_palavras = 15'd2;
    tick();
    start = 1'b1; num_palavras = 15'd5;
    chk("t4_state_load", state_dbg, 1);
    dado_valid = 1'b1; dado_in = 32'hA5A5_0001;
    expect_write(32'd0, 32'hA5A5_0001);
    tick();
    start = 1'b0;
    chk("t4_mid_state", state_dbg, 1);
    dado_in = 32'hA5A5_0002;
    expect_write(32'd1, 32'hA5A5_0002);
    tick();
    dado_valid = 1'b0;
    chk("t4_end_state", state_dbg, 2);
    tick(); tick();
    chk("t4_done", done, 1);
    check_writes("t4");

    // Reset after two of five words aborts; a new load restarts at address 0.
    start = 1'b1; num_palavras = 15'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dado_valid = 1'b1; dado_in = 32'hB000_0000 + 32'(i);
      expect_write(32'(i), 32'hB000_0000 + 32'(i));
      tick();
    end
    reset_n = 1'b0; dado_in = 32'hB000_0002;
    tick();
    chk("t5_rst_opmem", OpMemIns, 0);
    chk("t5_rst_hold", cpu_hold, 1);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_state", state_dbg, 0);
    chk("t5_rst_ready", dado_ready, 0);
    reset_n = 1'b1; dado_valid = 1'b0;
    tick(); tick();
    chk("t5_idle_opmem", OpMemIns, 0);
    check_writes("t5a");
    start = 1'b1; num_palavras = 15'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dado_valid = 1'b1; dado_in = 32'hC000_0000 + 32'(i);
      expect_write(32'(i), 32'hC000_0000 + 32'(i));
      tick();
      chk("t5_endl", endLeitura, 64'(i));
    end
    dado_valid = 1'b0;
    tick(); tick();
    chk("t5_done", done, 1);
    check_writes("t5b");

    // Reload from RUN with pc=7.
    pc = 32'd7;
    #1;
    chk("t6_ender_pc", endereco, 7);
    chk("t6_done_run", done, 1);
    start = 1'b1; num_palavras = 15'd1; dado_valid = 1'b1; dado_in = 32'hD00D_0001;
    tick();
    start = 1'b0;
    chk("t6_done_drop", done, 0);
    chk("t6_ender_zero", endereco, 0);
    chk("t6_hold", cpu_hold, 1);
    expect_write(32'd0, 32'hD00D_0001);
    tick();
    dado_valid = 1'b0;
    chk("t6_opmem", OpMemIns, 1);
    chk("t6_endl", endLeitura, 0);
    tick(); tick();
    chk("t6_done_back", done, 1);
    chk("t6_ender_back", endereco, 7);
    pc = 32'd9;
    #1;
    chk("t6_ender_follow", endereco, 9);
    check_writes("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
